// File: rtl/dkong_sound_cmd_if.sv
// Main-CPU side of the sound command interface: latch decode, analog trigger stretch,
// SACK synchronisation and command pending/timeout status.
module dkong_sound_cmd_if #(
    parameter int unsigned CLK_RATE     = 24576000,
    parameter int unsigned MIN_PULSE_US = 200,
    parameter int unsigned TIMEOUT_MS   = 50
) (
    input  logic       W_CLK_24576M,
    input  logic       W_RESETn,
    input  logic [9:0] I_CPU_A,
    input  logic [7:0] I_CPU_D,
    input  logic       I_CPU_WE,
    input  logic       I_SACK,
    output logic [4:0] O_3D_Q,
    output logic [6:0] O_6H_Q,
    output logic       O_5H_Q0,
    output logic [1:0] O_4H_Q,
    output logic [7:0] O_STAT
);

    // 64-bit intermediate: CLK_RATE * MIN_PULSE_US overflows 32 bits at the default rate
    localparam longint unsigned StretchL = 64'(CLK_RATE) * 64'(MIN_PULSE_US) / 64'd1000000;
    localparam longint unsigned TmoL     = 64'(CLK_RATE) / 64'd1000 * 64'(TIMEOUT_MS);
    localparam int unsigned     CW       = $clog2(StretchL + 1);
    localparam int unsigned     TW       = $clog2(TmoL + 1);
    localparam logic [CW-1:0]   STRETCH  = CW'(StretchL);
    localparam logic [TW-1:0]   TMO      = TW'(TmoL);

    typedef enum logic [1:0] {StIdle, StPend, StTout} state_e;

    logic [4:0]    d3_q, d3_d;
    logic [6:0]    h6_q, h6_d;
    logic [1:0]    h4_q, h4_d;
    logic          irq_q, irq_d;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    logic          sack_meta_q, sack_sync_q, sack_prev_q;
    logic          sack_edge, irq_fall;
    state_e        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tout_q, tout_d;

    always_comb begin
        d3_d  = d3_q;
        h6_d  = h6_q;
        h4_d  = h4_q;
        irq_d = irq_q;
        if (I_CPU_WE) begin
            if (I_CPU_A == 10'h000) begin
                d3_d = I_CPU_D[4:0];
            end else if (I_CPU_A[9:1] == 9'h040) begin
                h4_d[I_CPU_A[0]] = I_CPU_D[0];
            end else if (I_CPU_A[9:3] == 7'h20 && I_CPU_A[2:0] != 3'd7) begin
                h6_d[I_CPU_A[2:0]] = I_CPU_D[0];
            end else if (I_CPU_A == 10'h180) begin
                irq_d = ~I_CPU_D[0];
            end
        end
    end

    // Fall is detected on the next-state value so the counter loads on the same edge as the latch
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (h6_q[i] && !h6_d[i]) begin
                cnt_d[i] = STRETCH;
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    assign sack_edge = sack_sync_q ^ sack_prev_q;
    assign irq_fall  = irq_q & ~irq_d;

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        tout_d  = tout_q;
        if (irq_fall) begin
            state_d = StPend;
            tcnt_d  = '0;
            tout_d  = 1'b0;
        end else begin
            case (state_q)
                StIdle: ;
                StPend: begin
                    if (sack_edge) begin
                        state_d = StIdle;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                        if (tcnt_d == TMO) begin
                            state_d = StTout;
                            tout_d  = 1'b1;
                        end
                    end
                end
                StTout: if (sack_edge) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
        if (!W_RESETn) begin
            d3_q        <= 5'h00;
            h6_q        <= 7'h7F;
            h4_q        <= 2'b00;
            irq_q       <= 1'b1;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            sack_meta_q <= 1'b0;
            sack_sync_q <= 1'b0;
            sack_prev_q <= 1'b0;
            state_q     <= StIdle;
            tcnt_q      <= '0;
            tout_q      <= 1'b0;
        end else begin
            d3_q        <= d3_d;
            h6_q        <= h6_d;
            h4_q        <= h4_d;
            irq_q       <= irq_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
            sack_meta_q <= I_SACK;
            sack_sync_q <= sack_meta_q;
            sack_prev_q <= sack_sync_q;
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            tout_q      <= tout_d;
        end
    end

    always_comb begin
        O_6H_Q[6:3] = h6_q[6:3];
        for (int i = 0; i < 3; i++) O_6H_Q[i] = h6_q[i] & (cnt_q[i] == '0);
    end

    assign O_3D_Q  = d3_q;
    assign O_4H_Q  = h4_q;
    assign O_5H_Q0 = irq_q;
    assign O_STAT  = {(state_q != StIdle), tout_q, sack_sync_q, irq_q, h4_q, 2'b00};

endmodule
